// File: rtl/pico_io_bank.sv
// I/O bank for the PicoBlaze port bus: output registers, synchronised input channels,
// per-channel change capture and an acknowledged, maskable interrupt.
module pico_io_bank #(
  parameter int         N_OUT    = 4,
  parameter int         N_IN     = 4,
  parameter logic [7:0] OUT_BASE = 8'h00,
  parameter logic [7:0] IN_BASE  = 8'h10,
  parameter logic [7:0] MASK_ID  = OUT_BASE + 8'(N_OUT)
) (
  input  logic              clk,
  input  logic              cpu_reset,
  input  logic [7:0]        port_id,
  input  logic [7:0]        out_port,
  input  logic              write_strobe,
  input  logic              k_write_strobe,
  input  logic              read_strobe,
  output logic [7:0]        in_port,
  input  logic [8*N_IN-1:0] ext_in,
  output logic [8*N_OUT-1:0] ext_out,
  output logic              interrupt,
  input  logic              interrupt_ack
);

  localparam logic [7:0] STATUS_ID = IN_BASE + 8'(N_IN);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_HOLD} state_t;

  logic [N_OUT-1:0][7:0] r_out;
  logic [N_IN-1:0][7:0]  r_sync1, r_sync2, r_prev;
  logic [N_IN-1:0]       r_pending, r_mask;
  logic [7:0]            r_in_port;
  logic                  r_interrupt;
  state_t                r_state;

  logic [N_OUT-1:0]      w_out_we;
  logic                  w_mask_we;
  logic [N_IN-1:0]       w_change;
  logic [7:0]            w_rdata;
  logic                  w_status_rd;
  logic                  w_irq;

  // NOTE: every signal gets a default before the decode so no path leaves it unassigned (no latch).
  // write_strobe owns the cycle when both strobes fire; k_write_strobe only sees the low nibble.
  always_comb begin
    w_out_we  = '0;
    w_mask_we = 1'b0;
    if (write_strobe) begin
      for (int i = 0; i < N_OUT; i++)
        if (port_id == OUT_BASE + 8'(i)) w_out_we[i] = 1'b1;
      w_mask_we = (port_id == MASK_ID);
    end else if (k_write_strobe) begin
      for (int i = 0; i < N_OUT; i++)
        if (port_id[3:0] == OUT_BASE[3:0] + 4'(i)) w_out_we[i] = 1'b1;
      w_mask_we = (port_id[3:0] == MASK_ID[3:0]);
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    for (int i = 0; i < N_IN; i++)
      if (port_id == IN_BASE + 8'(i)) w_rdata = r_sync2[i];
    if (port_id == STATUS_ID) w_rdata = 8'(r_pending);
    if (port_id == MASK_ID)   w_rdata = 8'(r_mask);
  end

  always_comb begin
    for (int i = 0; i < N_IN; i++) w_change[i] = (r_sync2[i] != r_prev[i]);
  end

  assign w_status_rd = read_strobe && (port_id == STATUS_ID);
  assign w_irq       = |(r_pending & r_mask);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (cpu_reset) begin
      r_out     <= '0;
      r_mask    <= '0;
      r_pending <= '0;
      r_in_port <= 8'h00;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++)
        if (w_out_we[i]) r_out[i] <= out_port;
      if (w_mask_we) r_mask <= out_port[N_IN-1:0];
      r_sync1   <= ext_in;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      r_in_port <= w_rdata;
      // A change seen in the same cycle as a STATUS read survives the clear.
      r_pending <= (w_status_rd ? '0 : r_pending) | w_change;
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_reset) begin
      r_state     <= S_IDLE;
      r_interrupt <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_irq) begin
          r_state     <= S_ASSERT;
          r_interrupt <= 1'b1;
        end
        S_ASSERT: if (interrupt_ack) begin
          r_state     <= S_HOLD;
          r_interrupt <= 1'b0;
        end
        S_HOLD: if (!w_irq) r_state <= S_IDLE;
        default: begin
          r_state     <= S_IDLE;
          r_interrupt <= 1'b0;
        end
      endcase
    end
  end

  assign ext_out   = r_out;
  assign in_port   = r_in_port;
  assign interrupt = r_interrupt;

endmodule
